button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front-end stage for the clock/timer keys: conditions N_BTN raw active-low board keys into clean
//  single-cycle press pulses. Output bus `button[0:N_BTN-1]` feeds the timer/clock mode logic directly.
//  Each channel: 2-flop synchroniser, debounce FSM, edge pulse; optional auto-repeat for increment keys.
// PARAMETERS
//  N_BTN           4           number of key channels
//  CLK_HZ          50_000_000  clock frequency, Hz
//  DEBOUNCE_MS     20          stable time required on press and on release; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
//  REPEAT_DELAY_MS 500         hold time before first repeat pulse; RD_CYC = CLK_HZ/1000*REPEAT_DELAY_MS
//  REPEAT_RATE_MS  100         interval between repeat pulses; RR_CYC = CLK_HZ/1000*REPEAT_RATE_MS
//  REPEAT_MASK     4'b0100     [0:N_BTN-1]; 1 = channel auto-repeats (default: button[1], the increment key)
// PORTS
//  clock    in   1          system clock
//  reset    in   1          asynchronous, active-low reset
//  key_n    in   [0:N_BTN-1] raw keys, asynchronous, active-low (0 = pressed)
//  button   out  [0:N_BTN-1] press pulse, exactly 1 clock wide per accepted press (or per repeat)
//  pressed  out  [0:N_BTN-1] debounced level, 1 while key is considered held
// BEHAVIOUR
//  Reset (async, active-low): sync flops <= 1 (released), FSMs <= IDLE, counters <= 0, button <= 0, pressed <= 0.
//  Synchroniser: key_n -> s1 -> s2, 2 flops. The FSM uses s2 only.
//  Per-channel FSM (cnt width = $clog2 of the largest cycle count, min 1):
//   IDLE      : s2==0 -> PRESS_DB, cnt<=0.
//   PRESS_DB  : s2==1 -> IDLE (glitch, no pulse). Else if cnt==DB_CYC-1 -> HELD, button<=1, pressed<=1, cnt<=0. Else cnt++.
//   HELD      : s2==1 -> REL_DB, cnt<=0. Else repeat logic (if compiled in).
//   REL_DB    : s2==0 -> HELD (bounce, no new pulse; repeat timer restarts at 0). Else if cnt==DB_CYC-1 -> IDLE,
//               pressed<=0. Else cnt++.
//  pressed stays 1 through REL_DB and falls on the transition to IDLE.
//  Latency: key_n first sampled low at edge 1 and held low -> button high for exactly the cycle after edge DB_CYC+3.
//  Release latency: pressed falls after edge DB_CYC+3, counted from the first high sample.
//  button is registered and is forced to 0 on the cycle after any pulse. There are never 2 consecutive high cycles.
//  Channels are fully independent: simultaneous presses may produce coincident pulses, with no priority or masking.
//  Reset mid-press: everything returns to IDLE.
//  A key still held after reset deasserts is treated as a fresh press and pulses after the DB_CYC+3 latency.
//  Counters saturate only by FSM transition and never wrap. DB_CYC>=1 is required; DB_CYC==1 means 1 stable cycle.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//   - In HELD, channels with REPEAT_MASK[i]=1 count cycles.
//   - At cnt==RD_CYC-1: button<=1 and cnt<=0, then the repeat phase begins.
//   - In the repeat phase: button<=1 every RR_CYC cycles while held.
//   - Leaving HELD clears the repeat phase.
//  BTN_AUTOREPEAT_EN undefined:
//   - Exactly one pulse per accepted press. REPEAT_* parameters and the repeat counter are not synthesised.
// STRUCTURE
//  Package btn_pkg:
//   - typedef enum logic [1:0] {BTN_IDLE, BTN_PRESS_DB, BTN_HELD, BTN_REL_DB} btn_state_t
//   - function ms_to_cyc(int hz, int ms)
//  Sub-module btn_channel: one synchroniser + FSM + counters, single key.
//   Top instantiates N_BTN copies in a generate loop and passes REPEAT_MASK[i] as a per-channel parameter.
// TESTING (bench: CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CYC=4; REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3)
//  1. key_n[3] low from edge 1, held 20 cycles -> button[3] high only in the cycle after edge 7.
//     pressed[3] rises at the same point. All other channels stay 0.
//  2. key_n[0] low for 2 cycles, then high (glitch) -> no button[0] pulse, pressed[0] stays 0.
//  3. Held key, then key_n bounces high 2 cycles, low again -> no second pulse.
//     Final release held 4+ cycles -> pressed falls after edge (first high sample)+7.
//  4. key_n[1] and key_n[2] fall on the same edge -> button[1] and button[2] pulse in the same cycle.
//  5. reset asserted while key_n[2] is in PRESS_DB -> all outputs 0 immediately.
//     Key kept low through the reset deassert -> one pulse DB_CYC+3 cycles later.
//  6. BTN_AUTOREPEAT_EN, key_n[1] held 30 cycles -> pulses at press+0, +10, +13, +16, ...
//     key_n[3] held gives one pulse only. Without the macro, key_n[1] held gives one pulse only.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the key conditioning front end.
//   btn_state_t : per-channel debounce FSM state
//   ms_to_cyc   : converts a time in milliseconds to a clock-cycle count
//   cnt_width   : counter width able to hold 0 .. max_cyc-1 (minimum 1 bit)
// Optional feature macro used by the files that import this package:
//   BTN_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE,
      BTN_PRESS_DB,
      BTN_HELD,
      BTN_REL_DB
   } btn_state_t;

   // Integer divide first so the intermediate product stays small for
   // realistic clock rates (CLK_HZ is always a multiple of 1 kHz here).
   function automatic int ms_to_cyc(input int hz, input int ms);
      return (hz / 1000) * ms;
   endfunction

   // Counters only ever hold values up to max_cyc-1, so $clog2(max_cyc)
   // bits are enough; a single-cycle count still needs one bit.
   function automatic int cnt_width(input int max_cyc);
      return (max_cyc > 1) ? $clog2(max_cyc) : 1;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the raw key inputs and conditioned outputs of the key front end.
//   key_n   : raw active-low keys (0 = pressed), asynchronous to clock
//   button  : one-cycle press / repeat pulses
//   pressed : debounced "key is held" level
// Modports:
//   master : the side that owns the keys and consumes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
   parameter int N_BTN = 4
);

   logic [0:N_BTN-1] key_n;
   logic [0:N_BTN-1] button;
   logic [0:N_BTN-1] pressed;

   modport master (
      output key_n,
      input  button,
      input  pressed
   );

   modport slave (
      input  key_n,
      output button,
      output pressed
   );

endinterface

// File: rtl/button_conditioner_btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One key channel: 2-flop synchroniser, debounce FSM and press pulse, plus an
// optional auto-repeat timer for keys that are held down.
// Ports:
//   clock   : system clock
//   reset   : asynchronous, active-low reset
//   key_n   : raw active-low key
//   button  : registered pulse, one cycle per accepted press (or repeat)
//   pressed : registered debounced level, high from accept until release done
// Optional feature: BTN_AUTOREPEAT_EN enables the repeat timer on channels
// built with REPEAT_EN = 1; without it the repeat logic is not generated.
// -----------------------------------------------------------------------------
module btn_channel
   import btn_pkg::*;
#(
   parameter int DB_CYC    = 4,
   parameter int RD_CYC    = 10,
   parameter int RR_CYC    = 3,
   parameter bit REPEAT_EN = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic button,
   output logic pressed
);

`ifdef BTN_AUTOREPEAT_EN
   localparam int MAX_AB  = (DB_CYC > RD_CYC) ? DB_CYC : RD_CYC;
   localparam int MAX_CYC = (MAX_AB > RR_CYC) ? MAX_AB : RR_CYC;
`else
   localparam int MAX_CYC = DB_CYC;
`endif
   localparam int CNT_W = cnt_width(MAX_CYC);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYC - 1);
`endif

   logic       sync_1;
   logic       sync_2;
   btn_state_t state;
   logic [CNT_W-1:0] cnt;
`ifdef BTN_AUTOREPEAT_EN
   logic       rep_phase;
`endif

   // Two-flop synchroniser for the asynchronous key. Both flops reset to 1
   // (released) so a key held through reset is seen as a fresh falling edge
   // once reset lets go.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
      end
   end

   // Debounce FSM. The same counter times the press and release debounce and,
   // when auto-repeat is built in, the hold delay and repeat interval while the
   // key is held. button defaults low every cycle so it can only ever be a
   // single-cycle pulse. A repeat pulse is suppressed if the previous cycle
   // already pulsed, which keeps pulses apart even with a 1-cycle repeat rate.
   // A bounce during release debounce goes back to HELD with the timer and
   // repeat phase restarted, and never emits a new press pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= BTN_IDLE;
         cnt     <= '0;
         button  <= 1'b0;
         pressed <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_phase <= 1'b0;
`endif
      end else begin
         button <= 1'b0;
         case (state)
            BTN_IDLE: begin
               if (!sync_2) begin
                  state <= BTN_PRESS_DB;
                  cnt   <= '0;
               end
            end
            BTN_PRESS_DB: begin
               if (sync_2) begin
                  state <= BTN_IDLE;
               end else if (cnt == DB_LAST) begin
                  state   <= BTN_HELD;
                  button  <= 1'b1;
                  pressed <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            BTN_HELD: begin
               if (sync_2) begin
                  state <= BTN_REL_DB;
                  cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  rep_phase <= 1'b0;
`endif
               end
`ifdef BTN_AUTOREPEAT_EN
               else if (REPEAT_EN) begin
                  if (cnt == (rep_phase ? RR_LAST : RD_LAST)) begin
                     button    <= ~button;
                     cnt       <= '0;
                     rep_phase <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
`endif
            end
            BTN_REL_DB: begin
               if (!sync_2) begin
                  state <= BTN_HELD;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state   <= BTN_IDLE;
                  pressed <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= BTN_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions N_BTN raw active-low board keys into clean single-cycle press
// pulses for the clock/timer mode logic.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : button_conditioner_if.slave
//           key_n[0:N_BTN-1]   raw keys (0 = pressed)
//           button[0:N_BTN-1]  one-cycle press / repeat pulses
//           pressed[0:N_BTN-1] debounced held level
// Optional feature: BTN_AUTOREPEAT_EN adds auto-repeat on the channels whose
// REPEAT_MASK bit is set (default: button[1], the increment key).
// -----------------------------------------------------------------------------
module button_conditioner
   import btn_pkg::*;
#(
   parameter int               N_BTN           = 4,
   parameter int               CLK_HZ          = 50_000_000,
   parameter int               DEBOUNCE_MS     = 20,
   parameter int               REPEAT_DELAY_MS = 500,
   parameter int               REPEAT_RATE_MS  = 100,
   parameter logic [0:N_BTN-1] REPEAT_MASK     = 4'b0100
) (
   input  logic clock,
   input  logic reset,
   button_conditioner_if.slave bus
);

   localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int RD_CYC = ms_to_cyc(CLK_HZ, REPEAT_DELAY_MS);
   localparam int RR_CYC = ms_to_cyc(CLK_HZ, REPEAT_RATE_MS);

   logic [0:N_BTN-1] button_w;
   logic [0:N_BTN-1] pressed_w;

   // Channels are fully independent copies; each gets its own repeat enable
   // from the mask so only the increment-style keys auto-repeat.
   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_channel #(
         .DB_CYC   (DB_CYC),
         .RD_CYC   (RD_CYC),
         .RR_CYC   (RR_CYC),
         .REPEAT_EN(REPEAT_MASK[i])
      ) u_chan (
         .clock  (clock),
         .reset  (reset),
         .key_n  (bus.key_n[i]),
         .button (button_w[i]),
         .pressed(pressed_w[i])
      );
   end

   assign bus.button  = button_w;
   assign bus.pressed = pressed_w;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with CLK_HZ=1000, DEBOUNCE_MS=4
// (DB_CYC=4), REPEAT_DELAY_MS=10 (RD_CYC=10), REPEAT_RATE_MS=3 (RR_CYC=3).
// Inputs change and outputs are sampled on the falling clock edge; "cycle n"
// means the sample taken after the n-th rising edge since the key changed.
// Expected results depend on BTN_AUTOREPEAT_EN for the repeat scenarios.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int N_BTN   = 4;
   localparam int LATENCY = 7;

   logic clock = 1'b0;
   logic reset;
   int   check_count = 0;
   int   error_count = 0;

   button_conditioner_if #(.N_BTN(N_BTN)) bus ();

   button_conditioner #(
      .N_BTN          (N_BTN),
      .CLK_HZ         (1000),
      .DEBOUNCE_MS    (4),
      .REPEAT_DELAY_MS(10),
      .REPEAT_RATE_MS (3),
      .REPEAT_MASK    (4'b0100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Advance one full cycle and land on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Drive one raw key line.
   task automatic applyStimulus(input int ch, input logic level);
      bus.key_n[ch] = level;
   endtask

   // The single comparison point of the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [0:N_BTN-1] one_hot(input int ch);
      logic [0:N_BTN-1] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Release the given keys and follow the release debounce: pressed must
   // stay up through cycle LATENCY-1 and be gone from cycle LATENCY on.
   // extra_pulse/extra_cyc describe a repeat pulse still due before the FSM
   // notices the release (extra_cyc = 0 means none).
   task automatic release_keys(input string tag, input logic [0:N_BTN-1] chans,
                               input logic [0:N_BTN-1] extra_pulse, input int extra_cyc);
      logic [0:N_BTN-1] exp_btn;
      for (int ch = 0; ch < N_BTN; ch++)
         if (chans[ch]) applyStimulus(ch, 1'b1);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         exp_btn = (cyc == extra_cyc) ? extra_pulse : '0;
         checkOutput($sformatf("%s rel button c%0d", tag, cyc), bus.button, exp_btn);
         checkOutput($sformatf("%s rel pressed c%0d", tag, cyc), bus.pressed,
                     (cyc < LATENCY) ? chans : '0);
      end
   endtask

   initial begin
      logic [0:N_BTN-1] exp_btn;

      // Reset state with all keys released.
      reset     = 1'b0;
      bus.key_n = '1;
      repeat (3) tick();
      checkOutput("reset button", bus.button, '0);
      checkOutput("reset pressed", bus.pressed, '0);
      reset = 1'b1;
      repeat (2) tick();
      checkOutput("idle button", bus.button, '0);
      checkOutput("idle pressed", bus.pressed, '0);

      // 1. Single press on key 3, pulse and level after edge 7.
      $display("[TB] scenario 1: basic press on key 3");
      applyStimulus(3, 1'b0);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         checkOutput($sformatf("t1 button c%0d", cyc), bus.button,
                     (cyc == LATENCY) ? one_hot(3) : '0);
         checkOutput($sformatf("t1 pressed c%0d", cyc), bus.pressed,
                     (cyc >= LATENCY) ? one_hot(3) : '0);
      end
      release_keys("t1", one_hot(3), '0, 0);

      // 2. Two-cycle glitch on key 0 is rejected.
      $display("[TB] scenario 2: glitch on key 0");
      applyStimulus(0, 1'b0);
      repeat (2) tick();
      applyStimulus(0, 1'b1);
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         checkOutput($sformatf("t2 button c%0d", cyc), bus.button, '0);
         checkOutput($sformatf("t2 pressed c%0d", cyc), bus.pressed, '0);
      end

      // 3. Held key with a 2-cycle release bounce gives no second pulse.
      $display("[TB] scenario 3: release bounce on key 0");
      applyStimulus(0, 1'b0);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         checkOutput($sformatf("t3 button c%0d", cyc), bus.button,
                     (cyc == LATENCY) ? one_hot(0) : '0);
      end
      applyStimulus(0, 1'b1);
      repeat (2) tick();
      applyStimulus(0, 1'b0);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         checkOutput($sformatf("t3 bounce button c%0d", cyc), bus.button, '0);
         checkOutput($sformatf("t3 bounce pressed c%0d", cyc), bus.pressed, one_hot(0));
      end
      release_keys("t3", one_hot(0), '0, 0);

      // 4. Keys 1 and 2 pressed together pulse in the same cycle.
      $display("[TB] scenario 4: simultaneous keys 1 and 2");
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b0);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         checkOutput($sformatf("t4 button c%0d", cyc), bus.button,
                     (cyc == LATENCY) ? (one_hot(1) | one_hot(2)) : '0);
      end
      release_keys("t4", one_hot(1) | one_hot(2), '0, 0);

      // 5. Reset during press debounce, key kept low through reset release.
      $display("[TB] scenario 5: reset mid-press");
      applyStimulus(3, 1'b0);
      repeat (8) tick();
      checkOutput("t5 pre pressed", bus.pressed, one_hot(3));
      applyStimulus(2, 1'b0);
      repeat (4) tick();
      reset = 1'b0;
      #1;
      checkOutput("t5 async button", bus.button, '0);
      checkOutput("t5 async pressed", bus.pressed, '0);
      @(negedge clock);
      applyStimulus(3, 1'b1);
      repeat (2) tick();
      checkOutput("t5 held pressed", bus.pressed, '0);
      reset = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         checkOutput($sformatf("t5 button c%0d", cyc), bus.button,
                     (cyc == LATENCY) ? one_hot(2) : '0);
         checkOutput($sformatf("t5 pressed c%0d", cyc), bus.pressed,
                     (cyc >= LATENCY) ? one_hot(2) : '0);
      end
      release_keys("t5", one_hot(2), '0, 0);

      // 6. Long hold on key 1 (repeat key) and key 3 (no repeat).
      $display("[TB] scenario 6: long hold on keys 1 and 3");
      applyStimulus(1, 1'b0);
      applyStimulus(3, 1'b0);
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         exp_btn = (cyc == LATENCY) ? (one_hot(1) | one_hot(3)) : '0;
`ifdef BTN_AUTOREPEAT_EN
         if (cyc >= LATENCY + 10 && ((cyc - LATENCY - 10) % 3) == 0)
            exp_btn[1] = 1'b1;
`endif
         checkOutput($sformatf("t6 button c%0d", cyc), bus.button, exp_btn);
      end
`ifdef BTN_AUTOREPEAT_EN
      // Last repeat was at cycle 29; the next one (32) lands before the FSM
      // sees the release, i.e. release cycle 2.
      release_keys("t6", one_hot(1) | one_hot(3), one_hot(1), 2);
`else
      release_keys("t6", one_hot(1) | one_hot(3), '0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
